brick_load_ctrl: RTL and testbench

BRICK_LOAD_CTRL -- requirements
Module: brick_load_ctrl

---
 rtl/brick_load_ctrl_if.sv | 26 ++
 rtl/brick_load_ctrl.sv | 157 +++++++++++++++
 tb/tb_brick_load_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/brick_load_ctrl_if.sv
// Level-loader bundle: start/level request, layout ROM port, draw-engine handshake and status.
// master = loader controller, slave = the surrounding system (ROM, draw engine, game logic).
interface brick_load_ctrl_if;
  logic       start;
  logic [2:0] level;
  logic [8:0] rom_addr;
  logic [1:0] rom_data;
  logic       draw_req;
  logic [9:0] draw_x;
  logic [9:0] draw_y;
  logic [2:0] draw_color;
  logic       draw_ack;
  logic [5:0] brick_count;
  logic       busy;
  logic       done;

  modport master (
    input  start, level, rom_data, draw_ack,
    output rom_addr, draw_req, draw_x, draw_y, draw_color, brick_count, busy, done
  );

  modport slave (
    output start, level, rom_data, draw_ack,
    input  rom_addr, draw_req, draw_x, draw_y, draw_color, brick_count, busy, done
  );
endinterface

// File: rtl/brick_load_ctrl.sv
// Walks a level's brick layout ROM in raster order and asks the draw engine to paint each non-empty brick.
// Empty brick costs 3 cycles, drawn brick 4 + ack wait; draw_req holds its coordinates until draw_ack.
module brick_load_ctrl #(
  parameter int NUM_COLS = 10,
  parameter int NUM_ROWS = 5,
  parameter int BRICK_W  = 32,
  parameter int BRICK_H  = 16,
  parameter int X_ORIGIN = 0,
  parameter int Y_ORIGIN = 32
) (
  input  logic               clk,
  input  logic               resetn,
  brick_load_ctrl_if.master  bus
);

  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam logic [5:0]       LAST_IDX = 6'(NUM_COLS * NUM_ROWS - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    READ  = 3'd2,
    DRAW  = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       level_q;
  logic [5:0]       idx;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [9:0]       x_q;
  logic [9:0]       y_q;
  logic [2:0]       color_q;
  logic [5:0]       count_q;

  logic       accept;
  logic       latch_brick;
  logic       ack_hit;
  logic       advance;
  logic [9:0] x_calc;
  logic [9:0] y_calc;

  function automatic logic [2:0] type_color(input logic [1:0] t);
    case (t)
      2'd1:    type_color = 3'b100;
      2'd2:    type_color = 3'b110;
      2'd3:    type_color = 3'b010;
      default: type_color = 3'b000;
    endcase
  endfunction

  // Pixel position wraps modulo 1024 by design: only the low 10 bits reach the draw engine.
  assign x_calc = 10'(X_ORIGIN + int'(col) * BRICK_W);
  assign y_calc = 10'(Y_ORIGIN + int'(row) * BRICK_H);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    latch_brick = 1'b0;
    ack_hit     = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = READ;
      READ: begin
        if (bus.rom_data != 2'd0) begin
          latch_brick = 1'b1;
          state_nxt   = DRAW;
        end else begin
          state_nxt = NEXT;
        end
      end
      DRAW: begin
        if (bus.draw_ack) begin
          ack_hit   = 1'b1;
          state_nxt = NEXT;
        end
      end
      NEXT: begin
        if (idx == LAST_IDX) begin
          state_nxt = DONE;
        end else begin
          advance   = 1'b1;
          state_nxt = FETCH;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      level_q <= '0;
      idx     <= '0;
      col     <= '0;
      row     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      count_q <= '0;
    end else begin
      if (accept) begin
        level_q <= bus.level;
        idx     <= '0;
        col     <= '0;
        row     <= '0;
        count_q <= '0;
      end
      if (latch_brick) begin
        x_q     <= x_calc;
        y_q     <= y_calc;
        color_q <= type_color(bus.rom_data);
      end
      if (ack_hit) begin
        count_q <= count_q + 6'd1;
      end
      if (advance) begin
        idx <= idx + 6'd1;
        if (col == LAST_COL) begin
          col <= '0;
          row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

  assign bus.rom_addr    = {level_q, idx};
  assign bus.draw_req    = (state == DRAW);
  assign bus.draw_x      = x_q;
  assign bus.draw_y      = y_q;
  assign bus.draw_color  = color_q;
  assign bus.brick_count = count_q;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = (state == DONE);

endmodule

// File: tb/tb_brick_load_ctrl.sv
// Bench for brick_load_ctrl: synchronous layout ROM model, draw-engine responder with programmable ack delay,
// and a raster-order reference model giving the expected request list, brick count and start-to-done latency.
module tb_brick_load_ctrl;

  logic clk;
  logic resetn;
  int   cyc;
  int   checks;
  int   errors;

  brick_load_ctrl_if bus();

  brick_load_ctrl dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  logic [1:0]  rom_mem [0:511];
  logic [22:0] obs_q [$];
  logic [22:0] exp_q [$];
  int          exp_lat;
  int          ack_delay;
  bit          stray_en;
  bit          stray_force;
  int          req_run;
  int          req_cycles;
  int          stab_viol;
  int          addr_viol;
  int          done_cnt;
  int          done_cyc;
  logic [2:0]  exp_level;
  logic [22:0] snap;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Synchronous ROM: data for the address presented in one cycle appears in the next.
  initial begin
    bus.rom_data = 2'd0;
    forever begin
      @(posedge clk);
      bus.rom_data <= rom_mem[bus.rom_addr];
    end
  end

  // Draw-engine responder and observer, evaluated mid-cycle.
  initial begin
    bus.draw_ack = 1'b0;
    req_run = 0;
    snap = '0;
    forever begin
      @(negedge clk);
      if (bus.draw_req) begin
        bus.draw_ack = (req_run >= ack_delay);
        if (req_run == 0) snap = {bus.draw_x, bus.draw_y, bus.draw_color};
        else if ({bus.draw_x, bus.draw_y, bus.draw_color} != snap) stab_viol++;
        req_run++;
        req_cycles++;
        if (bus.draw_ack) obs_q.push_back({bus.draw_x, bus.draw_y, bus.draw_color});
      end else begin
        req_run = 0;
        bus.draw_ack = stray_force | (stray_en & ($urandom_range(0, 1) == 1));
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.busy && bus.rom_addr[8:6] !== exp_level) addr_viol++;
    end
  end

  function automatic logic [2:0] spec_color(input logic [1:0] t);
    logic [2:0] c;
    c = 3'b000;
    if (t == 2'd1) c = 3'b100;
    if (t == 2'd2) c = 3'b110;
    if (t == 2'd3) c = 3'b010;
    return c;
  endfunction

  // Expected requests in raster order plus start-to-done cycle count for a given ack delay.
  task automatic model_load(input logic [2:0] lvl, input int dly);
    exp_q.delete();
    exp_lat = 1;
    for (int i = 0; i < 50; i++) begin
      logic [1:0] t;
      int x;
      int y;
      t = rom_mem[{lvl, 6'(i)}];
      if (t == 2'd0) begin
        exp_lat += 3;
      end else begin
        exp_lat += 4 + dly;
        x = (i % 10) * 32;
        y = 32 + (i / 10) * 16;
        exp_q.push_back({10'(x), 10'(y), spec_color(t)});
      end
    end
  endtask

  task automatic clear_level(input logic [2:0] lvl);
    for (int i = 0; i < 64; i++) rom_mem[{lvl, 6'(i)}] = 2'd0;
  endtask

  task automatic do_load(input logic [2:0] lvl, input int dly, input bit mid_start,
                         output int lat, output bit timed_out);
    int c;
    int n;
    obs_q.delete();
    done_cnt   = 0;
    req_cycles = 0;
    stab_viol  = 0;
    addr_viol  = 0;
    exp_level  = lvl;
    ack_delay  = dly;
    timed_out  = 1'b0;
    @(negedge clk);
    bus.level = lvl;
    bus.start = 1'b1;
    c = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.level = 3'($urandom);
    n = 0;
    while (done_cnt == 0 && !timed_out) begin
      @(negedge clk);
      n++;
      if (mid_start && n >= 20 && n < 23) begin
        bus.start = 1'b1;
        bus.level = ~lvl;
      end else begin
        bus.start = 1'b0;
      end
      if (n > 5000) timed_out = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    lat = done_cyc - c;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.draw_req !== 1'b0) begin errors++; $display("FAIL reset_draw_req: got %b want 0", bus.draw_req); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.brick_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.brick_count); end
    checks++; if ({bus.draw_x, bus.draw_y, bus.draw_color} !== 23'd0) begin errors++;
      $display("FAIL reset_draw_regs: got x=%0d y=%0d c=%b want 0", bus.draw_x, bus.draw_y, bus.draw_color); end
    checks++; if (bus.rom_addr !== 9'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d want 0", bus.rom_addr); end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.draw_req !== 1'b0) begin errors++;
      $display("FAIL idle_after_reset: got busy=%b req=%b want 0/0", bus.busy, bus.draw_req); end
  endtask

  task automatic test_empty_level();
    int lat;
    bit to;
    clear_level(3'd0);
    do_load(3'd0, 0, 1'b0, lat, to);
    checks++; if (to) begin errors++; $display("FAIL empty_timeout: no done within bound"); end
    checks++; if (lat !== 151) begin errors++; $display("FAIL empty_latency: got %0d want 151", lat); end
    checks++; if (req_cycles !== 0) begin errors++; $display("FAIL empty_req: got %0d req cycles want 0", req_cycles); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL empty_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (bus.brick_count !== 6'd0) begin errors++; $display("FAIL empty_count: got %0d want 0", bus.brick_count); end
  endtask

  task automatic test_single_brick();
    int lat;
    bit to;
    clear_level(3'd2);
    rom_mem[{3'd2, 6'd13}] = 2'd2;
    stray_force = 1'b1;
    do_load(3'd2, 0, 1'b0, lat, to);
    stray_force = 1'b0;
    checks++; if (to || obs_q.size() !== 1) begin errors++; $display("FAIL single_req_cnt: got %0d requests want 1", obs_q.size()); end
    else begin
      checks++; if (obs_q[0] !== {10'd96, 10'd48, 3'b110}) begin errors++;
        $display("FAIL single_coords: got x=%0d y=%0d c=%b want 96 48 110", obs_q[0][22:13], obs_q[0][12:3], obs_q[0][2:0]); end
    end
    checks++; if (bus.brick_count !== 6'd1) begin errors++; $display("FAIL single_count: got %0d want 1", bus.brick_count); end
    checks++; if (lat !== 152) begin errors++; $display("FAIL single_latency: got %0d want 152", lat); end
  endtask

  task automatic test_ack_delay();
    int lat;
    bit to;
    clear_level(3'd1);
    rom_mem[{3'd1, 6'd49}] = 2'd1;
    do_load(3'd1, 5, 1'b0, lat, to);
    checks++; if (req_cycles !== 6) begin errors++; $display("FAIL delay_req_cycles: got %0d want 6", req_cycles); end
    checks++; if (stab_viol !== 0) begin errors++; $display("FAIL delay_stability: got %0d changes want 0", stab_viol); end
    checks++; if (obs_q.size() !== 1 || obs_q[0] !== {10'd288, 10'd96, 3'b100}) begin errors++;
      $display("FAIL delay_coords: got %0d requests want one at 288,96 colour 100", obs_q.size()); end
    checks++; if (to || lat !== 157) begin errors++; $display("FAIL delay_latency: got %0d want 157", lat); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL delay_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_full_level();
    int lat;
    bit to;
    logic [22:0] got;
    for (int i = 0; i < 64; i++) rom_mem[{3'd3, 6'(i)}] = 2'd3;
    model_load(3'd3, 0);
    do_load(3'd3, 0, 1'b0, lat, to);
    checks++; if (obs_q.size() !== 50) begin errors++; $display("FAIL full_req_cnt: got %0d want 50", obs_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      checks++; if (got !== exp_q[i]) begin errors++;
        $display("FAIL full_req[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
    checks++; if (bus.brick_count !== 6'd50) begin errors++; $display("FAIL full_count: got %0d want 50", bus.brick_count); end
    checks++; if (addr_viol !== 0) begin errors++; $display("FAIL full_addr_level: got %0d bad cycles want 0", addr_viol); end
    checks++; if (to || lat !== exp_lat) begin errors++; $display("FAIL full_latency: got %0d want %0d", lat, exp_lat); end
  endtask

  task automatic test_random_levels();
    int lat;
    bit to;
    logic [2:0] lvl;
    int dly;
    int bad;
    logic [22:0] got;
    stray_en = 1'b1;
    for (int it = 0; it < 4; it++) begin
      lvl = 3'($urandom_range(0, 7));
      dly = $urandom_range(0, 3);
      for (int i = 0; i < 64; i++) rom_mem[{lvl, 6'(i)}] = ($urandom_range(0, 2) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
      model_load(lvl, dly);
      do_load(lvl, dly, 1'b0, lat, to);
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
        got = (i < obs_q.size()) ? obs_q[i] : '1;
        if (got !== exp_q[i]) bad++;
      end
      checks++; if (bad !== 0 || obs_q.size() !== exp_q.size()) begin errors++;
        $display("FAIL rand%0d_requests: got %0d requests (%0d wrong) want %0d", it, obs_q.size(), bad, exp_q.size()); end
      checks++; if (bus.brick_count !== 6'(exp_q.size())) begin errors++;
        $display("FAIL rand%0d_count: got %0d want %0d", it, bus.brick_count, exp_q.size()); end
      checks++; if (to || lat !== exp_lat) begin errors++; $display("FAIL rand%0d_latency: got %0d want %0d", it, lat, exp_lat); end
      checks++; if (stab_viol !== 0 || addr_viol !== 0) begin errors++;
        $display("FAIL rand%0d_stability: got %0d/%0d violations want 0/0", it, stab_viol, addr_viol); end
      repeat (3) @(negedge clk);
      checks++; if (bus.brick_count !== 6'(exp_q.size()) || bus.busy !== 1'b0) begin errors++;
        $display("FAIL rand%0d_hold: got count=%0d busy=%b want %0d/0", it, bus.brick_count, bus.busy, exp_q.size()); end
    end
    stray_en = 1'b0;
  endtask

  task automatic test_start_ignored();
    int lat;
    bit to;
    int busy_seen;
    logic [22:0] got;
    for (int i = 0; i < 64; i++) rom_mem[{3'd5, 6'(i)}] = (i % 3 == 0) ? 2'(1 + i % 3 + (i % 2)) : 2'd0;
    for (int i = 0; i < 64; i++) rom_mem[{3'd2, 6'(i)}] = 2'd3;
    model_load(3'd5, 1);
    do_load(3'd5, 1, 1'b1, lat, to);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL midstart_done_cnt: got %0d want 1", done_cnt); end
    checks++; if (to || lat !== exp_lat) begin errors++; $display("FAIL midstart_latency: got %0d want %0d", lat, exp_lat); end
    checks++; if (addr_viol !== 0) begin errors++; $display("FAIL midstart_level: got %0d bad cycles want 0", addr_viol); end
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++;
      $display("FAIL midstart_req_cnt: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      checks++; if (got !== exp_q[i]) begin errors++; $display("FAIL midstart_req[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
    busy_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.busy) busy_seen++;
    end
    checks++; if (busy_seen !== 0) begin errors++; $display("FAIL midstart_restart: got %0d busy cycles want 0", busy_seen); end
  endtask

  task automatic test_reset_mid_draw();
    int n;
    int seen;
    clear_level(3'd4);
    for (int i = 0; i < 5; i++) rom_mem[{3'd4, 6'(i)}] = 2'd1;
    obs_q.delete();
    exp_level = 3'd4;
    ack_delay = 3;
    addr_viol = 0;
    @(negedge clk);
    bus.level = 3'd4;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!(bus.draw_req && bus.brick_count >= 6'd2) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n >= 500) begin errors++; $display("FAIL rst_draw_wait: got no third request want one"); end
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (bus.draw_req !== 1'b0 || bus.busy !== 1'b0) begin errors++;
      $display("FAIL rst_mid_draw: got req=%b busy=%b want 0/0", bus.draw_req, bus.busy); end
    checks++; if (bus.brick_count !== 6'd0 || bus.rom_addr !== 9'd0) begin errors++;
      $display("FAIL rst_mid_regs: got count=%0d addr=%0d want 0/0", bus.brick_count, bus.rom_addr); end
    resetn = 1'b1;
    stray_force = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.draw_req || bus.busy || bus.done) seen++;
    end
    stray_force = 1'b0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_stray_ack: got %0d active cycles want 0", seen); end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    resetn      = 1'b0;
    bus.start   = 1'b0;
    bus.level   = 3'd0;
    ack_delay   = 0;
    stray_en    = 1'b0;
    stray_force = 1'b0;
    exp_level   = 3'd0;
    done_cnt    = 0;
    done_cyc    = 0;
    req_cycles  = 0;
    stab_viol   = 0;
    addr_viol   = 0;
    for (int i = 0; i < 512; i++) rom_mem[i] = 2'd0;
    repeat (3) @(negedge clk);
    test_reset();
    test_empty_level();
    test_single_brick();
    test_ack_delay();
    test_full_level();
    test_random_levels();
    test_start_ignored();
    test_reset_mid_draw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
